// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU command sequencer.
//   - Controller state encoding
//   - ALU L (arith/logic select) and ALUOp encodings
//   - Operand and result widths
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned RES_W  = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StMul  = 2'd2,
    StDone = 2'd3
  } state_e;

  // L select
  localparam logic ALU_ARITH = 1'b0;
  localparam logic ALU_LOGIC = 1'b1;

  // ALUOp codes, L = ALU_ARITH
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  // ALUOp codes, L = ALU_LOGIC
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration of the 4x4 unsigned multiply.
//   acc_i, q_i   : current accumulator and multiplier/low-product register
//   alu_r_i      : ACC + M from the shared ALU adder
//   alu_carry_i  : carry out of that addition
//   acc_o, q_o   : next accumulator and multiplier/low-product register
module mul_step
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] alu_r_i,
  input  logic              alu_carry_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] q_o
);

  // The carry becomes the new ACC MSB, so the 8-bit product never overflows.
  always_comb begin
    if (q_i[0]) begin
      {acc_o, q_o} = {alu_carry_i, alu_r_i, q_i[DATA_W-1:1]};
    end else begin
      {acc_o, q_o} = {1'b0, acc_i, q_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// Command sequencer for the 4-bit ALU.
//   cmd_*     : command handshake (single ALU op or 4x4 unsigned multiply)
//   alu_*_o   : operand/opcode drive to the external ALU
//   alu_*_i   : combinational ALU result and flags
//   res_*     : result handshake (8-bit data plus zero/carry/sign flags)
// The ALU is not instantiated here so that it can be shared at the next level.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // Command channel
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_mul_i,
  input  logic [2:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  // ALU drive
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [1:0]        alu_op_o,
  output logic              alu_l_o,
  input  logic [DATA_W-1:0] alu_r_i,
  input  logic              alu_zero_i,
  input  logic              alu_carry_i,
  input  logic              alu_sign_i,
  // Result channel
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [RES_W-1:0]  res_data_o,
  output logic              res_zero_o,
  output logic              res_carry_o,
  output logic              res_sign_o
);

  state_e             state_q;
  logic [DATA_W-1:0]  a_q;    // operand A, multiplicand M during multiply
  logic [DATA_W-1:0]  b_q;    // operand B, multiplier / low product Q during multiply
  logic [2:0]         op_q;
  logic [DATA_W-1:0]  acc_q;
  logic [1:0]         cnt_q;
  logic [RES_W-1:0]   res_data_q;
  logic               res_zero_q;
  logic               res_carry_q;
  logic               res_sign_q;
  logic               res_valid_q;

  logic [DATA_W-1:0]  acc_nxt;
  logic [DATA_W-1:0]  q_nxt;

  mul_step u_mul_step (
    .acc_i       (acc_q),
    .q_i         (b_q),
    .alu_r_i     (alu_r_i),
    .alu_carry_i (alu_carry_i),
    .acc_o       (acc_nxt),
    .q_o         (q_nxt)
  );

  // ALU ports are idle-zero outside EXEC/MUL so a future arbiter sees a quiet master.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = '0;
    alu_l_o  = 1'b0;
    unique case (state_q)
      StExec: begin
        alu_a_o             = a_q;
        alu_b_o             = b_q;
        {alu_l_o, alu_op_o} = op_q;
      end
      StMul: begin
        alu_a_o  = acc_q;
        alu_b_o  = a_q;
        alu_l_o  = ALU_ARITH;
        alu_op_o = OP_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
      res_sign_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            a_q     <= cmd_a_i;
            b_q     <= cmd_b_i;
            op_q    <= cmd_op_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= cmd_mul_i ? StMul : StExec;
          end
        end
        StExec: begin
          res_data_q  <= {{(RES_W - DATA_W){1'b0}}, alu_r_i};
          res_zero_q  <= alu_zero_i;
          res_carry_q <= alu_carry_i;
          res_sign_q  <= alu_sign_i;
          state_q     <= StDone;
        end
        StMul: begin
          acc_q <= acc_nxt;
          b_q   <= q_nxt;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            res_data_q  <= {acc_nxt, q_nxt};
            res_zero_q  <= ({acc_nxt, q_nxt} == '0);
            res_carry_q <= 1'b0;
            res_sign_q  <= acc_nxt[DATA_W-1];
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Result registers settle on entry; valid is raised registered one cycle later.
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
          end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_zero_o  = res_zero_q;
  assign res_carry_o = res_carry_q;
  assign res_sign_o  = res_sign_q;

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_mul;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic       alu_l;
  logic [3:0] alu_r;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_sign;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic       res_carry;
  logic       res_sign;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  alu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_mul_i   (cmd_mul),
    .cmd_op_i    (cmd_op),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_l_o     (alu_l),
    .alu_r_i     (alu_r),
    .alu_zero_i  (alu_zero),
    .alu_carry_i (alu_carry),
    .alu_sign_i  (alu_sign),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_zero_o  (res_zero),
    .res_carry_o (res_carry),
    .res_sign_o  (res_sign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference 4-bit ALU; carry is the 5th bit of the arithmetic result (borrow for SUB/DEC).
  logic [4:0] alu_t;
  always_comb begin
    alu_t = '0;
    if (!alu_l) begin
      case (alu_op)
        2'b00:   alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        2'b01:   alu_t = {1'b0, alu_a} - {1'b0, alu_b};
        2'b10:   alu_t = {1'b0, alu_a} + 5'd1;
        default: alu_t = {1'b0, alu_a} - 5'd1;
      endcase
    end else begin
      case (alu_op)
        2'b00:   alu_t = {1'b0, alu_a & alu_b};
        2'b01:   alu_t = {1'b0, alu_a | alu_b};
        2'b10:   alu_t = {1'b0, alu_a ^ alu_b};
        default: alu_t = {1'b0, ~alu_a};
      endcase
    end
    alu_r     = alu_t[3:0];
    alu_carry = alu_t[4];
    alu_zero  = (alu_t[3:0] == 4'h0);
    alu_sign  = alu_t[3];
  end

  // Present a command at a negedge, wait (bounded) for it to be taken; returns at the
  // negedge after the accepting edge with cmd_valid dropped.
  task automatic issue(input logic m, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_mul   = m;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (cmd_ready !== 1'b1 && g < 20) begin
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for res_valid; latency is counted in edges from the accepting edge.
  task automatic wait_valid(output int lat);
    int g = 0;
    while (res_valid !== 1'b1 && g < 20) begin
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mul   = 1'b0;
    cmd_op    = 3'b000;
    cmd_a     = 4'h0;
    cmd_b     = 4'h0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: ready=%b valid=%b want 1 0", cmd_ready, res_valid);
    end
    total++;
    if ({res_data, res_zero, res_carry, res_sign} !== 11'h000) begin
      bad++;
      $display("FAIL reset_res: data=%h flags=%b%b%b want 00 000", res_data, res_zero,
               res_carry, res_sign);
    end
    total++;
    if ({alu_a, alu_b, alu_op, alu_l} !== 11'h000) begin
      bad++;
      $display("FAIL reset_alu: a=%h b=%h op=%b l=%b want zeros", alu_a, alu_b, alu_op, alu_l);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    int lat;
    issue(1'b0, 3'b000, 4'h9, 4'h8);
    total++;
    if (alu_a !== 4'h9 || alu_b !== 4'h8 || {alu_l, alu_op} !== 3'b000 || cmd_ready !== 1'b0)
    begin
      bad++;
      $display("FAIL add_exec: a=%h b=%h lop=%b ready=%b want 9 8 000 0", alu_a, alu_b,
               {alu_l, alu_op}, cmd_ready);
    end
    wait_valid(lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL add_latency: got %0d want 2", lat);
    end
    total++;
    if (res_data !== 8'h01 || res_carry !== 1'b1 || res_zero !== 1'b0 || res_sign !== 1'b0)
    begin
      bad++;
      $display("FAIL add_result: data=%h z=%b c=%b s=%b want 01 0 1 0", res_data, res_zero,
               res_carry, res_sign);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL add_ready_excl: ready=%b want 0 while valid", cmd_ready);
    end
    handshake();
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || alu_a !== 4'h0) begin
      bad++;
      $display("FAIL add_release: ready=%b valid=%b alu_a=%h want 1 0 0", cmd_ready,
               res_valid, alu_a);
    end
  endtask

  task automatic test_single_ops();
    // {op, a, b, data, zero, carry, sign}
    logic [2:0] t_op   [4] = '{3'b001, 3'b010, 3'b101, 3'b111};
    logic [3:0] t_a    [4] = '{4'h3, 4'hF, 4'h9, 4'h3};
    logic [3:0] t_b    [4] = '{4'h5, 4'h0, 4'h6, 4'h0};
    logic [7:0] t_data [4] = '{8'h0E, 8'h00, 8'h0F, 8'h0C};
    logic [2:0] t_zcs  [4] = '{3'b011, 3'b110, 3'b001, 3'b001};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, t_op[i], t_a[i], t_b[i]);
      wait_valid(lat);
      total++;
      if (res_data !== t_data[i] || {res_zero, res_carry, res_sign} !== t_zcs[i]) begin
        bad++;
        $display("FAIL single_op%0d: data=%h zcs=%b want %h %b", i, res_data,
                 {res_zero, res_carry, res_sign}, t_data[i], t_zcs[i]);
      end
      handshake();
    end
  endtask

  task automatic test_mul_15x15();
    logic [3:0] exp_acc [4] = '{4'h0, 4'h7, 4'hB, 4'hD};
    int lat;
    issue(1'b1, 3'b000, 4'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (alu_a !== exp_acc[i] || alu_b !== 4'hF || {alu_l, alu_op} !== 3'b000) begin
        bad++;
        $display("FAIL mul_iter%0d: alu_a=%h alu_b=%h lop=%b want %h F 000", i, alu_a,
                 alu_b, {alu_l, alu_op}, exp_acc[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    wait_valid(lat);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL mul_latency: got %0d want 5", lat);
    end
    total++;
    if (res_data !== 8'hE1 || res_sign !== 1'b1 || res_carry !== 1'b0 || res_zero !== 1'b0)
    begin
      bad++;
      $display("FAIL mul_15x15: data=%h z=%b c=%b s=%b want E1 0 0 1", res_data, res_zero,
               res_carry, res_sign);
    end
    handshake();
  endtask

  task automatic test_mul_table();
    logic [3:0] t_a    [3] = '{4'h0, 4'h7, 4'h6};
    logic [3:0] t_b    [3] = '{4'h7, 4'h0, 4'h5};
    logic [7:0] t_data [3] = '{8'h00, 8'h00, 8'h1E};
    logic       t_zero [3] = '{1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      // res_ready raised early must not shorten the command.
      res_ready = 1'b1;
      issue(1'b1, 3'b000, t_a[i], t_b[i]);
      wait_valid(lat);
      total++;
      if (lat !== 5 || res_data !== t_data[i] || res_zero !== t_zero[i] || res_sign !== 1'b0)
      begin
        bad++;
        $display("FAIL mul_tab%0d: lat=%0d data=%h z=%b s=%b want 5 %h %b 0", i, lat,
                 res_data, res_zero, res_sign, t_data[i], t_zero[i]);
      end
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    res_ready = 1'b0;
    issue(1'b0, 3'b110, 4'hA, 4'h5);
    wait_valid(lat);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (res_valid !== 1'b1 || res_data !== 8'h0F || cmd_ready !== 1'b0 ||
          {res_zero, res_carry, res_sign} !== 3'b001) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b zcs=%b want 1 0F 0 001", i,
                 res_valid, res_data, cmd_ready, {res_zero, res_carry, res_sign});
      end
      @(posedge clk);
      @(negedge clk);
    end
    handshake();
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: ready=%b valid=%b want 1 0", cmd_ready, res_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    logic seen = 1'b0;
    issue(1'b1, 3'b000, 4'h6, 4'h5);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (alu_a !== 4'h3 || alu_b !== 4'h6) begin
      bad++;
      $display("FAIL rst_pre: alu_a=%h alu_b=%h want 3 6", alu_a, alu_b);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h00 ||
        {alu_a, alu_b, alu_op, alu_l} !== 11'h000) begin
      bad++;
      $display("FAIL rst_mid: ready=%b valid=%b data=%h a=%h b=%h want 1 0 00 0 0",
               cmd_ready, res_valid, res_data, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_valid: res_valid seen=%b want 0", seen);
    end
    issue(1'b0, 3'b000, 4'h2, 4'h3);
    wait_valid(lat);
    total++;
    if (lat !== 2 || res_data !== 8'h05) begin
      bad++;
      $display("FAIL rst_after: lat=%0d data=%h want 2 05", lat, res_data);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic       b_mul [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0] b_op  [3] = '{3'b000, 3'b000, 3'b100};
    logic [3:0] b_a   [3] = '{4'h3, 4'h3, 4'hC};
    logic [3:0] b_b   [3] = '{4'h4, 4'h4, 4'hA};
    logic [7:0] b_exp [3] = '{8'h07, 8'h0C, 8'h08};
    logic [7:0] got   [3] = '{8'h00, 8'h00, 8'h00};
    int idx = 0;
    int nres = 0;
    int extra = 0;
    logic overlap = 1'b0;
    logic acc_now;
    logic take;
    cmd_valid = 1'b1;
    cmd_mul   = b_mul[0];
    cmd_op    = b_op[0];
    cmd_a     = b_a[0];
    cmd_b     = b_b[0];
    res_ready = 1'b1;
    for (int c = 0; c < 60 && nres < 3; c++) begin
      acc_now = cmd_valid && cmd_ready;
      take    = res_valid && res_ready;
      if (cmd_ready && res_valid) overlap = 1'b1;
      if (take) begin
        got[nres] = res_data;
        nres++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc_now) begin
        idx++;
        if (idx < 3) begin
          cmd_mul = b_mul[idx];
          cmd_op  = b_op[idx];
          cmd_a   = b_a[idx];
          cmd_b   = b_b[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (res_valid === 1'b1) extra++;
      @(posedge clk);
      @(negedge clk);
    end
    res_ready = 1'b0;
    total++;
    if (nres !== 3 || idx !== 3 || extra !== 0) begin
      bad++;
      $display("FAIL b2b_count: results=%0d accepts=%0d extra=%0d want 3 3 0", nres, idx,
               extra);
    end
    total++;
    if (overlap !== 1'b0) begin
      bad++;
      $display("FAIL b2b_overlap: ready&valid seen=%b want 0", overlap);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] !== b_exp[i]) begin
        bad++;
        $display("FAIL b2b_res%0d: got %h want %h", i, got[i], b_exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_single_ops();
    test_mul_15x15();
    test_mul_table();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
